// File: rtl/cpu_mc_ctl_if.sv
// Bundle of run-control, fetch, load/store, jump and write-back signals between
// the multi-cycle controller (master) and the datapath/memory side (slave).
interface cpu_mc_ctl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  logic                  i_sys_en;
  logic                  o_sys_busy;
  logic                  o_sys_err;
  logic [2:0]            o_sys_state;
  logic [ADDR_WIDTH-1:0] o_ifu_pc;
  // Handshakes: req stays high for the whole wait state; a transfer completes
  // on the rising edge where req && ack, and ack is ignored while req is low.
  logic                  o_ram_inst_req;
  logic                  i_ram_inst_ack;
  logic [INST_WIDTH-1:0] i_ram_inst;
  logic [INST_WIDTH-1:0] o_idu_inst;
  logic                  i_idu_ctr_ram_en;
  logic                  o_lsu_req;
  logic                  i_lsu_ack;
  logic                  i_exu_jmp_en;
  logic [ADDR_WIDTH-1:0] i_exu_jmp_pc;
  logic                  i_idu_ctr_reg_wr_en;
  logic                  o_wbu_gpr_wr_en;
  logic [CNT_WIDTH-1:0]  o_ret_cnt;
  logic [CNT_WIDTH-1:0]  o_cyc_cnt;

  modport master (
    input  i_sys_en, i_ram_inst_ack, i_ram_inst, i_idu_ctr_ram_en, i_lsu_ack,
           i_exu_jmp_en, i_exu_jmp_pc, i_idu_ctr_reg_wr_en,
    output o_sys_busy, o_sys_err, o_sys_state, o_ifu_pc, o_ram_inst_req,
           o_idu_inst, o_lsu_req, o_wbu_gpr_wr_en, o_ret_cnt, o_cyc_cnt
  );

  modport slave (
    output i_sys_en, i_ram_inst_ack, i_ram_inst, i_idu_ctr_ram_en, i_lsu_ack,
           i_exu_jmp_en, i_exu_jmp_pc, i_idu_ctr_reg_wr_en,
    input  o_sys_busy, o_sys_err, o_sys_state, o_ifu_pc, o_ram_inst_req,
           o_idu_inst, o_lsu_req, o_wbu_gpr_wr_en, o_ret_cnt, o_cyc_cnt
  );
endinterface

// File: rtl/cpu_mc_ctl.sv
// Multi-cycle CPU sequencer IF->ID->EX->[LS]->WB with fetch/data wait timeout.
// Define CPU_MC_CTL_PERF_EN to build the retired-instruction and busy-cycle counters.
module cpu_mc_ctl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 'h8000_0000,
  parameter int                    TIMEOUT    = 16,
  parameter int                    CNT_WIDTH  = 32
) (
  input logic         i_sys_clk,
  input logic         i_sys_rst_n,
  cpu_mc_ctl_if.master bus
);
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_IF   = 3'd1;
  localparam logic [2:0] ST_ID   = 3'd2;
  localparam logic [2:0] ST_EX   = 3'd3;
  localparam logic [2:0] ST_LS   = 3'd4;
  localparam logic [2:0] ST_WB   = 3'd5;
  localparam logic [2:0] ST_ERR  = 3'd7;
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [2:0]            state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc, pc_nxt_q;
  logic [INST_WIDTH-1:0] inst_q;
  logic                  waiting, timeout_hit, jmp_bad;

  assign waiting = (state == ST_IF && !bus.i_ram_inst_ack) ||
                   (state == ST_LS && !bus.i_lsu_ack);
  assign jmp_bad = bus.i_exu_jmp_en && (bus.i_exu_jmp_pc[1:0] != 2'b00);

  // The wait counter holds the number of un-acked cycles already spent in the
  // current IF/LS visit; the cycle that would make it TIMEOUT goes to ERR.
  if (TIMEOUT > 0) begin : g_timeout
    logic [WAIT_W-1:0] wait_cnt;
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n)  wait_cnt <= '0;
      else if (waiting)  wait_cnt <= wait_cnt + WAIT_W'(1);
      else               wait_cnt <= '0;
    end
    assign timeout_hit = waiting && (wait_cnt == WAIT_W'(TIMEOUT - 1));
  end else begin : g_no_timeout
    assign timeout_hit = 1'b0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.i_sys_en) state_nxt = ST_IF;
      ST_IF: begin
        if (bus.i_ram_inst_ack) state_nxt = ST_ID;
        else if (timeout_hit)   state_nxt = ST_ERR;
      end
      ST_ID:   state_nxt = ST_EX;
      ST_EX: begin
        if (jmp_bad)                   state_nxt = ST_ERR;
        else if (bus.i_idu_ctr_ram_en) state_nxt = ST_LS;
        else                           state_nxt = ST_WB;
      end
      ST_LS: begin
        if (bus.i_lsu_ack)    state_nxt = ST_WB;
        else if (timeout_hit) state_nxt = ST_ERR;
      end
      ST_WB:   state_nxt = bus.i_sys_en ? ST_IF : ST_IDLE;
      ST_ERR:  state_nxt = ST_ERR;
      default: state_nxt = ST_ERR;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      pc_nxt_q <= RESET_PC;
      inst_q   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IF && bus.i_ram_inst_ack) inst_q <= bus.i_ram_inst;
      if (state == ST_EX)
        pc_nxt_q <= bus.i_exu_jmp_en ? bus.i_exu_jmp_pc : pc + ADDR_WIDTH'(4);
      if (state == ST_WB) pc <= pc_nxt_q;
    end
  end

  assign bus.o_sys_state     = state;
  assign bus.o_sys_busy      = (state != ST_IDLE) && (state != ST_ERR);
  assign bus.o_sys_err       = (state == ST_ERR);
  assign bus.o_ifu_pc        = pc;
  assign bus.o_idu_inst      = inst_q;
  assign bus.o_ram_inst_req  = (state == ST_IF);
  assign bus.o_lsu_req       = (state == ST_LS);
  assign bus.o_wbu_gpr_wr_en = (state == ST_WB) && bus.i_idu_ctr_reg_wr_en;

`ifdef CPU_MC_CTL_PERF_EN
  logic [CNT_WIDTH-1:0] ret_cnt, cyc_cnt;
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      ret_cnt <= '0;
      cyc_cnt <= '0;
    end else begin
      if (state == ST_WB)     ret_cnt <= ret_cnt + CNT_WIDTH'(1);
      if (bus.o_sys_busy)     cyc_cnt <= cyc_cnt + CNT_WIDTH'(1);
    end
  end
  assign bus.o_ret_cnt = ret_cnt;
  assign bus.o_cyc_cnt = cyc_cnt;
`else
  assign bus.o_ret_cnt = '0;
  assign bus.o_cyc_cnt = '0;
`endif
endmodule
